// File: rtl/branch_predict_unit.sv
// Branch target buffer with 2-bit direction counters, mispredict
// detection, next-PC select and saturating branch statistics.
module branch_predict_unit #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   fetch_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    output logic              btb_hit,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_is_br,
    input  logic              ex_is_jmp,
    input  logic              ex_cmp,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              flush,
    output logic [1:0]        pcmux_sel,
    output logic [PERF_W-1:0] br_count,
    output logic [PERF_W-1:0] mispred_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [PERF_W-1:0] ONE = PERF_W'(1);

    logic             valid  [ENTRIES];
    logic [TAG_W-1:0] tag    [ENTRIES];
    logic [XLEN-1:0]  target [ENTRIES];
    logic [1:0]       ctr    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] e_tag;
    logic             res;
    logic             act;
    logic             mis_t;
    logic             mis_nt;
    logic             e_hit;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[XLEN-1:IDX_W+2];
    assign e_idx = ex_pc[IDX_W+1:2];
    assign e_tag = ex_pc[XLEN-1:IDX_W+2];

    // Lookup reads the registered array only, so a same-cycle update is not seen
    assign btb_hit     = ~rst & valid[f_idx] & (tag[f_idx] == f_tag);
    assign pred_taken  = btb_hit & ctr[f_idx][1];
    assign pred_target = pred_taken ? target[f_idx] : '0;

    assign res    = ~rst & ex_valid & (ex_is_br | ex_is_jmp);
    assign act    = ex_is_jmp | ex_cmp;
    assign mis_t  = res & act
                  & (~ex_pred_taken | (ex_pred_target != ex_target));
    assign mis_nt = res & ~act & ex_pred_taken;
    assign e_hit  = valid[e_idx] & (tag[e_idx] == e_tag);

    always_comb begin
        flush     = 1'b0;
        pcmux_sel = 2'd0;
        if (mis_t) begin
            flush     = 1'b1;
            pcmux_sel = 2'd2;
        end else if (mis_nt) begin
            flush     = 1'b1;
            pcmux_sel = 2'd1;
        end else if (pred_taken) begin
            pcmux_sel = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= 2'b01;
            end
            br_count      <= '0;
            mispred_count <= '0;
        end else if (res) begin
            if (br_count != '1)
                br_count <= br_count + ONE;
            if ((mis_t | mis_nt) && (mispred_count != '1))
                mispred_count <= mispred_count + ONE;
            if (e_hit) begin
                if (act && (ctr[e_idx] != 2'b11))
                    ctr[e_idx] <= ctr[e_idx] + 2'd1;
                else if (!act && (ctr[e_idx] != 2'b00))
                    ctr[e_idx] <= ctr[e_idx] - 2'd1;
                if (act)
                    target[e_idx] <= ex_target;
            end else if (act) begin
                // Jumps start strongly taken, branches weakly taken
                valid[e_idx]  <= 1'b1;
                tag[e_idx]    <= e_tag;
                target[e_idx] <= ex_target;
                ctr[e_idx]    <= ex_is_jmp ? 2'b11 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed vector table, saturation/reset sequence and randomized run
// against an array-based predictor model.
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        btb_hit;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_br;
    logic        ex_is_jmp;
    logic        ex_cmp;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush;
    logic [1:0]  pcmux_sel;
    logic [3:0]  br_count;
    logic [3:0]  mispred_count;

    always #5 clk = ~clk;

    branch_predict_unit #(.ENTRIES(16), .XLEN(32), .PERF_W(4)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .btb_hit(btb_hit), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_is_br(ex_is_br), .ex_is_jmp(ex_is_jmp), .ex_cmp(ex_cmp),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .flush(flush),
        .pcmux_sel(pcmux_sel), .br_count(br_count),
        .mispred_count(mispred_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: one record per BTB slot, counter kept as an integer 0..3
    typedef struct {
        bit        v;
        bit [25:0] tag;
        bit [31:0] tgt;
        int        ctr;
    } ment_t;

    ment_t m [16];
    int    m_br;
    int    m_mis;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m[i].v   = 0;
            m[i].ctr = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit hit,
                                     output bit pt, output bit [31:0] tgt);
        int i;
        i   = int'(pc[5:2]);
        hit = m[i].v && (m[i].tag == pc[31:6]);
        pt  = hit && (m[i].ctr >= 2);
        tgt = pt ? m[i].tgt : 32'h0;
    endfunction

    function automatic bit m_mispredict(output bit taken_miss);
        bit res, act;
        res = ex_valid && (ex_is_br || ex_is_jmp);
        act = ex_is_jmp || ex_cmp;
        taken_miss = res && act
                   && (!ex_pred_taken || ex_pred_target != ex_target);
        return taken_miss || (res && !act && ex_pred_taken);
    endfunction

    function automatic void m_clock();
        bit res, act, mis, mt;
        int i;
        if (rst) begin
            m_reset();
            return;
        end
        res = ex_valid && (ex_is_br || ex_is_jmp);
        act = ex_is_jmp || ex_cmp;
        mis = m_mispredict(mt);
        if (!res) return;
        if (m_br < 15) m_br++;
        if (mis && m_mis < 15) m_mis++;
        i = int'(ex_pc[5:2]);
        if (m[i].v && m[i].tag == ex_pc[31:6]) begin
            if (act) begin
                if (m[i].ctr < 3) m[i].ctr++;
                m[i].tgt = ex_target;
            end else if (m[i].ctr > 0) begin
                m[i].ctr--;
            end
        end else if (act) begin
            m[i].v   = 1;
            m[i].tag = ex_pc[31:6];
            m[i].tgt = ex_target;
            m[i].ctr = ex_is_jmp ? 3 : 2;
        end
    endfunction

    task automatic check_model();
        bit hit, pt, mt, mis;
        bit [31:0] tgt;
        logic [1:0] sel;
        m_lookup(fetch_pc, hit, pt, tgt);
        mis = m_mispredict(mt);
        if (rst) begin
            hit = 0; pt = 0; tgt = 0; mis = 0; mt = 0;
        end
        sel = mt ? 2'd2 : mis ? 2'd1 : pt ? 2'd3 : 2'd0;
        chk("rnd_hit", btb_hit, hit);
        chk("rnd_pt", pred_taken, pt);
        chk("rnd_ptgt", pred_target, tgt);
        chk("rnd_flush", flush, mis);
        chk("rnd_sel", pcmux_sel, sel);
        chk("rnd_brc", br_count, m_br);
        chk("rnd_misc", mispred_count, m_mis);
    endtask

    task automatic edge_commit();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic idle_ex();
        ex_valid = 0; ex_is_br = 0; ex_is_jmp = 0; ex_cmp = 0;
        ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    endtask

    typedef struct {
        logic [31:0] fpc;
        logic        v, br, jmp, cmp;
        logic [31:0] epc, etgt;
        logic        ept;
        logic [31:0] eptgt;
        logic        hit, pt;
        logic [31:0] ptgt;
        logic        fl;
        logic [1:0]  sel;
        int          brc, misc;
    } vec_t;

    vec_t vq[$];

    initial begin
        bit hit, pt;
        bit [31:0] tgt;
        int kind;

        vq.push_back('{32'h100, 0,0,0,0, 32'h0,   32'h0,   0, 32'h0,
                       0,0,32'h0,   0,2'd0, 0,0});
        vq.push_back('{32'h200, 1,1,0,1, 32'h100, 32'h180, 0, 32'h0,
                       0,0,32'h0,   1,2'd2, 0,0});
        vq.push_back('{32'h100, 0,0,0,0, 32'h0,   32'h0,   0, 32'h0,
                       1,1,32'h180, 0,2'd3, 1,1});
        vq.push_back('{32'h100, 1,1,0,0, 32'h100, 32'h0,   1, 32'h180,
                       1,1,32'h180, 1,2'd1, 1,1});
        vq.push_back('{32'h100, 0,0,0,0, 32'h0,   32'h0,   0, 32'h0,
                       1,0,32'h0,   0,2'd0, 2,2});
        vq.push_back('{32'h300, 1,1,0,1, 32'h100, 32'h1C0, 1, 32'h180,
                       0,0,32'h0,   1,2'd2, 2,2});
        vq.push_back('{32'h100, 0,0,0,0, 32'h0,   32'h0,   0, 32'h0,
                       1,1,32'h1C0, 0,2'd3, 3,3});
        vq.push_back('{32'h100, 1,1,0,1, 32'h100, 32'h1C0, 1, 32'h1C0,
                       1,1,32'h1C0, 0,2'd3, 3,3});
        vq.push_back('{32'h140, 1,0,1,0, 32'h140, 32'h200, 0, 32'h0,
                       0,0,32'h0,   1,2'd2, 4,3});
        vq.push_back('{32'h140, 0,0,0,0, 32'h0,   32'h0,   0, 32'h0,
                       1,1,32'h200, 0,2'd3, 5,4});
        vq.push_back('{32'h100, 0,0,0,0, 32'h0,   32'h0,   0, 32'h0,
                       0,0,32'h0,   0,2'd0, 5,4});
        vq.push_back('{32'h100, 0,1,0,1, 32'h180, 32'h300, 0, 32'h0,
                       0,0,32'h0,   0,2'd0, 5,4});
        vq.push_back('{32'h140, 1,1,0,0, 32'h180, 32'h0,   0, 32'h0,
                       1,1,32'h200, 0,2'd3, 5,4});
        vq.push_back('{32'h180, 0,0,0,0, 32'h0,   32'h0,   0, 32'h0,
                       0,0,32'h0,   0,2'd0, 6,4});

        rst = 1;
        fetch_pc = 32'h100;
        idle_ex();
        #1;
        @(negedge clk);
        chk("rst_hit", btb_hit, 0);
        chk("rst_sel", pcmux_sel, 0);
        edge_commit();
        edge_commit();
        rst = 0;

        foreach (vq[k]) begin
            fetch_pc = vq[k].fpc;
            ex_valid = vq[k].v;  ex_is_br = vq[k].br;
            ex_is_jmp = vq[k].jmp; ex_cmp = vq[k].cmp;
            ex_pc = vq[k].epc;   ex_target = vq[k].etgt;
            ex_pred_taken = vq[k].ept; ex_pred_target = vq[k].eptgt;
            @(negedge clk);
            chk($sformatf("v%0d_hit", k), btb_hit, vq[k].hit);
            chk($sformatf("v%0d_pt", k), pred_taken, vq[k].pt);
            chk($sformatf("v%0d_ptgt", k), pred_target, vq[k].ptgt);
            chk($sformatf("v%0d_flush", k), flush, vq[k].fl);
            chk($sformatf("v%0d_sel", k), pcmux_sel, vq[k].sel);
            chk($sformatf("v%0d_brc", k), br_count, vq[k].brc);
            chk($sformatf("v%0d_misc", k), mispred_count, vq[k].misc);
            edge_commit();
        end

        // Twenty mispredicted taken branches saturate both 4-bit counters
        fetch_pc = 32'h0;
        ex_valid = 1; ex_is_br = 1; ex_is_jmp = 0; ex_cmp = 1;
        ex_pc = 32'h400; ex_target = 32'h480;
        ex_pred_taken = 0; ex_pred_target = 0;
        for (int n = 0; n < 20; n++) edge_commit();
        @(negedge clk);
        chk("sat_brc", br_count, 15);
        chk("sat_misc", mispred_count, 15);

        fetch_pc = 32'h400;
        @(negedge clk);
        chk("pre_rst_hit", btb_hit, 1);
        rst = 1;
        #1;
        chk("in_rst_hit", btb_hit, 0);
        chk("in_rst_pt", pred_taken, 0);
        chk("in_rst_ptgt", pred_target, 0);
        chk("in_rst_flush", flush, 0);
        chk("in_rst_sel", pcmux_sel, 0);
        edge_commit();
        rst = 0;
        idle_ex();
        @(negedge clk);
        chk("post_rst_hit", btb_hit, 0);
        chk("post_rst_brc", br_count, 0);
        chk("post_rst_misc", mispred_count, 0);
        edge_commit();

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            fetch_pc = {24'h0, 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            ex_pc = {24'h0, 2'($urandom_range(0, 3)),
                     4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            ex_valid = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 2);
            ex_is_br = (kind == 1);
            ex_is_jmp = (kind == 2);
            ex_cmp = $urandom_range(0, 1);
            ex_target = 32'($urandom_range(0, 7)) << 4;
            if ($urandom_range(0, 9) < 7) begin
                m_lookup(ex_pc, hit, pt, tgt);
                ex_pred_taken = pt;
                ex_pred_target = tgt;
            end else begin
                ex_pred_taken = $urandom_range(0, 1);
                ex_pred_target = 32'($urandom_range(0, 7)) << 4;
            end
            @(negedge clk);
            check_model();
            edge_commit();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the next-PC select/flush logic. Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Provides a same-cycle prediction to fetch, and trains on branches resolved in EX. Detects mispredictions and drives the flush signal and the 2-bit PC-mux select. Also keeps saturating performance counters for resolved branches and mispredictions.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, at least 2; IDX_W = log2(ENTRIES)
XLEN, 32, address/PC width
PERF_W, 32, width of each performance counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
fetch_pc  input  XLEN  PC being fetched this cycle
pred_taken  output  1  fetch prediction: BTB hit and counter MSB = 1
pred_target  output  XLEN  predicted target; 0 when pred_taken = 0
btb_hit  output  1  valid entry whose tag matches fetch_pc
ex_valid  input  1  EX holds a real instruction (not a bubble)
ex_pc  input  XLEN  PC of the EX instruction
ex_is_br  input  1  EX instruction is a conditional branch
ex_is_jmp  input  1  EX instruction is an unconditional jump (jal/jalr)
ex_cmp  input  1  branch condition outcome; ignored when ex_is_jmp = 1
ex_target  input  XLEN  computed target
ex_pred_taken  input  1  prediction carried down the pipeline with this instruction
ex_pred_target  input  XLEN  predicted target carried down the pipeline
flush  output  1  squash IF/ID this cycle
pcmux_sel  output  2  0 = pc+4; 1 = ex_pc+4 (recovery); 2 = ex_target; 3 = pred_target
br_count  output  PERF_W  number of resolved branches and jumps
mispred_count  output  PERF_W  number of mispredictions

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. Bits [1:0] are ignored.
- Entry contents: valid, tag, target[XLEN], ctr[1:0].
- Lookup is combinational from the registered array. btb_hit, pred_taken and pred_target have zero latency relative to fetch_pc.
- Resolve qualifier: res = ex_valid & (ex_is_br | ex_is_jmp). Actual taken: act = ex_is_jmp | ex_cmp.
- Misprediction, evaluated only when res = 1:
  - mis_t = act & (~ex_pred_taken | ex_pred_target != ex_target)
  - mis_nt = ~act & ex_pred_taken
- Output priority (combinational):
  - mis_t: flush = 1, pcmux_sel = 2.
  - else mis_nt: flush = 1, pcmux_sel = 1.
  - else pred_taken: flush = 0, pcmux_sel = 3.
  - else flush = 0, pcmux_sel = 0.
  - A mispredict always overrides a concurrent fetch prediction.
- Training, on the clock edge when res = 1, at the entry indexed by ex_pc:
  - Hit (valid and tag match): ctr saturates up on act, down otherwise (00 ↔ 11 range). target is written with ex_target when act = 1. Target is unchanged when not taken.
  - Miss and act = 1: allocate (overwrite). valid = 1, tag and target written, ctr = 11 for a jump, 10 for a branch.
  - Miss and act = 0: no change.
- Read/write collision: a lookup and an update to the same index in one cycle return the pre-update contents. There is no bypass.
- Performance counters, updated when res = 1:
  - br_count increments by 1.
  - mispred_count increments by 1 when mis_t | mis_nt.
  - Both saturate at all-ones and never wrap.
- Reset, on a rising clk edge with rst = 1:
  - All valid bits cleared, all ctr = 01, both performance counters = 0.
  - With rst held, outputs are btb_hit = 0, pred_taken = 0, pred_target = 0, pcmux_sel = 0, flush = 0.
  - Reset overrides any concurrent training. Tag and target storage need not be cleared.
- ex_valid = 0: no training, no counter change, flush = 0. A bubble never flushes.

Test Plan:
1. Reset, then fetch_pc = 0x100 → btb_hit = 0, pred_taken = 0, pcmux_sel = 0, both counters = 0.
2. Branch at ex_pc = 0x100, ex_cmp = 1, ex_target = 0x180, ex_pred_taken = 0 → flush = 1, pcmux_sel = 2, mispred_count = 1. Next cycle fetch_pc = 0x100 gives btb_hit = 1, pred_taken = 1, pred_target = 0x180, pcmux_sel = 3.
3. Same branch resolved not taken, ex_pred_taken = 1 → flush = 1, pcmux_sel = 1, ctr 10 → 01. Then lookup of 0x100 gives btb_hit = 1, pred_taken = 0.
4. Taken branch with ex_pred_taken = 1 and ex_pred_target = 0x180, but ex_target = 0x1C0 → flush = 1, pcmux_sel = 2. Entry target becomes 0x1C0.
5. ENTRIES = 16: train 0x100, then train taken jump 0x140 (same index, different tag) → 0x100 now misses, 0x140 hits with ctr = 11. A same-cycle lookup of 0x140 during the write still misses.
6. With PERF_W = 4, resolve 20 mispredicted branches → both counters hold at 15. Assert rst mid-stream → all entries invalid, counters 0 on the next cycle.
